// File: rtl/ma_pipe_adder.sv
// ma_pipe_adder: WIDTH-bit adder with the carry chain cut into SEG-bit
// registered segments and a valid/ready stall. MA_PIPE_OVF_EN adds Ovf.
module ma_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef MA_PIPE_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int STAGES = WIDTH / SEG;
  localparam int L = STAGES - 1;

  logic adv;

  assign adv = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int HI = (k + 1) * SEG;

    logic           vi;
    logic           ci;
    logic [SEG-1:0] xa;
    logic [SEG-1:0] xb;
    logic [SEG-1:0] seg;
    logic           co;
    logic [HI-1:0]  ns;
    logic           v;
    logic           c;
    logic [HI-1:0]  s;

    assign {co, seg} = {1'b0, xa} + {1'b0, xb}
                     + {{SEG{1'b0}}, ci};

    if (k == 0) begin : src
      assign vi = in_valid;
      assign ci = Cin;
      assign xa = A[SEG-1:0];
      assign xb = B[SEG-1:0];
      assign ns = seg;
    end else begin : src
      assign vi = g[k-1].v;
      assign ci = g[k-1].c;
      assign xa = g[k-1].up.ua[SEG-1:0];
      assign xb = g[k-1].up.ub[SEG-1:0];
      assign ns = {seg, g[k-1].s};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        s <= '0;
      end else if (adv) begin
        v <= vi;
        c <= co;
        s <= ns;
      end
    end

    // operand bits not yet summed ride along, shrinking by SEG per stage
    if (k < L) begin : up
      logic [WIDTH-HI-1:0] ua;
      logic [WIDTH-HI-1:0] ub;
      logic [WIDTH-HI-1:0] na;
      logic [WIDTH-HI-1:0] nb;

      if (k == 0) begin : fwd
        assign na = A[WIDTH-1:HI];
        assign nb = B[WIDTH-1:HI];
      end else begin : fwd
        assign na = g[k-1].up.ua[WIDTH-k*SEG-1:SEG];
        assign nb = g[k-1].up.ub[WIDTH-k*SEG-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ua <= '0;
          ub <= '0;
        end else if (adv) begin
          ua <= na;
          ub <= nb;
        end
      end
    end
  end

  assign out_valid = g[L].v;
  assign S         = g[L].s;
  assign Cout      = g[L].c;

`ifdef MA_PIPE_OVF_EN
  logic ovf_q;
  logic msb_cin;

  // carry into the MSB recovered from the MSB sum bit
  assign msb_cin = g[L].xa[SEG-1] ^ g[L].xb[SEG-1]
                 ^ g[L].seg[SEG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= msb_cin ^ g[L].co;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ma_pipe_adder.sv
// tb_ma_pipe_adder: scoreboard bench for ma_pipe_adder (16/4 and 8/8).
// Covers reset, latency, streaming, stalls and mid-stream reset.
module tb_ma_pipe_adder;
  localparam int W  = 16;
  localparam int SG = 4;
  localparam int ST = W / SG;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         Cout;

  logic         v1;
  logic         ir1;
  logic [7:0]   a1;
  logic [7:0]   b1;
  logic         c1;
  logic         ov1;
  logic         r1;
  logic [7:0]   s1;
  logic         co1;

`ifdef MA_PIPE_OVF_EN
  logic         ovf;
  logic         ovf1;
`endif

  int total = 0;
  int bad = 0;

  logic [W:0]   q[$];
  logic         r_ret;
  logic         r_hit;
  logic         r_took;
  logic [W:0]   r_got;
  logic [W:0]   r_exp;

  ma_pipe_adder #(.WIDTH(W), .SEG(SG)) u0 (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .Cin(Cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S(S),
    .Cout(Cout)
`ifdef MA_PIPE_OVF_EN
    ,
    .Ovf(ovf)
`endif
  );

  ma_pipe_adder #(.WIDTH(8), .SEG(8)) u1 (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(v1),
    .in_ready(ir1),
    .A(a1),
    .B(b1),
    .Cin(c1),
    .out_valid(ov1),
    .out_ready(r1),
    .S(s1),
    .Cout(co1)
`ifdef MA_PIPE_OVF_EN
    ,
    .Ovf(ovf1)
`endif
  );

  always #5 clk = ~clk;

  // one cycle from a negedge: drive, push accepted op, pop retiring one
  task automatic step(
    input  logic         v,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c,
    input  logic         ordy,
    output logic         ret,
    output logic         hit,
    output logic         took,
    output logic [W:0]   got,
    output logic [W:0]   exp
  );
    in_valid  = v;
    A         = a;
    B         = b;
    Cin       = c;
    out_ready = ordy;
    #1;
    ret  = out_valid && out_ready;
    took = in_valid && in_ready;
    got  = {Cout, S};
    hit  = 1'b1;
    exp  = '0;
    if (ret) begin
      if (q.size() == 0) hit = 1'b0;
      else exp = q.pop_front();
    end
    if (took)
      q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    total += 4;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid got=%b want=0", out_valid);
    end
    if (S !== '0) begin
      bad++;
      $display("FAIL rst_s got=%h want=0", S);
    end
    if (Cout !== 1'b0) begin
      bad++;
      $display("FAIL rst_cout got=%b want=0", Cout);
    end
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry();
    logic ev;
    in_valid  = 1'b1;
    A         = 16'hFFFF;
    B         = 16'h0001;
    Cin       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i <= ST; i++) begin
      ev = (i == ST);
      total++;
      if (out_valid !== ev) begin
        bad++;
        $display("FAIL carry_lat edge=%0d got=%b want=%b",
                 i, out_valid, ev);
      end
      if (i < ST) @(negedge clk);
    end
    total++;
    if ({Cout, S} !== 17'h10000) begin
      bad++;
      $display("FAIL carry_sum got=%h want=10000", {Cout, S});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n_loop = 0;
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1,
           r_ret, r_hit, r_took, r_got, r_exp);
      if (r_ret) begin
        n_loop++;
        total++;
        if (!r_hit || r_got !== r_exp) begin
          bad++;
          $display("FAIL b2b got=%h want=%h hit=%b",
                   r_got, r_exp, r_hit);
        end
      end
    end
    n = n_loop;
    for (int i = 0; i < ST + 2; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1,
           r_ret, r_hit, r_took, r_got, r_exp);
      if (r_ret) begin
        n++;
        total++;
        if (!r_hit || r_got !== r_exp) begin
          bad++;
          $display("FAIL b2b_drain got=%h want=%h", r_got, r_exp);
        end
      end
    end
    total += 3;
    if (n_loop != 100 - ST) begin
      bad++;
      $display("FAIL b2b_rate got=%0d want=%0d", n_loop, 100 - ST);
    end
    if (n != 100) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=100", n);
    end
    if (q.size() != 0) begin
      bad++;
      $display("FAIL b2b_left got=%0d want=0", q.size());
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic [W+1:0] snap;
    while (!out_valid && k < 10) begin
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0,
           r_ret, r_hit, r_took, r_got, r_exp);
      k++;
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_fill got=%b want=1", out_valid);
    end
    snap = {out_valid, Cout, S};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0,
           r_ret, r_hit, r_took, r_got, r_exp);
      total += 2;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready got=%b want=0", in_ready);
      end
      if ({out_valid, Cout, S} !== snap) begin
        bad++;
        $display("FAIL bp_hold got=%h want=%h",
                 {out_valid, Cout, S}, snap);
      end
    end
    for (int i = 0; i < ST + 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1,
           r_ret, r_hit, r_took, r_got, r_exp);
      if (r_ret) begin
        total++;
        if (!r_hit || r_got !== r_exp) begin
          bad++;
          $display("FAIL bp_drain got=%h want=%h", r_got, r_exp);
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL bp_left got=%0d want=0", q.size());
    end
  endtask

  task automatic test_random_stall();
    int acc = 0;
    int cyc = 0;
    while (acc < 1000 && cyc < 8000) begin
      step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
           1'($urandom), 1'($urandom),
           r_ret, r_hit, r_took, r_got, r_exp);
      cyc++;
      if (r_took) acc++;
      if (r_ret) begin
        total++;
        if (!r_hit || r_got !== r_exp) begin
          bad++;
          $display("FAIL rnd got=%h want=%h hit=%b",
                   r_got, r_exp, r_hit);
        end
      end
    end
    for (int i = 0; i < ST + 4; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1,
           r_ret, r_hit, r_took, r_got, r_exp);
      if (r_ret) begin
        total++;
        if (!r_hit || r_got !== r_exp) begin
          bad++;
          $display("FAIL rnd_drain got=%h want=%h", r_got, r_exp);
        end
      end
    end
    total += 2;
    if (acc != 1000) begin
      bad++;
      $display("FAIL rnd_accept got=%0d want=1000", acc);
    end
    if (q.size() != 0) begin
      bad++;
      $display("FAIL rnd_left got=%0d want=0", q.size());
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    logic seen = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1,
           r_ret, r_hit, r_took, r_got, r_exp);
    #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_valid got=%b want=0", out_valid);
    end
    if (S !== '0) begin
      bad++;
      $display("FAIL mid_s got=%h want=0", S);
    end
    if (Cout !== 1'b0) begin
      bad++;
      $display("FAIL mid_cout got=%b want=0", Cout);
    end
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_ready got=%b want=1", in_ready);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < ST + 2; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1,
           r_ret, r_hit, r_took, r_got, r_exp);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_ghost got=%b want=0", out_valid);
      end
    end
    step(1'b1, 16'h1234, 16'h0001, 1'b1, 1'b1,
         r_ret, r_hit, r_took, r_got, r_exp);
    while (!seen && k < 10) begin
      step(1'b0, '0, '0, 1'b0, 1'b1,
           r_ret, r_hit, r_took, r_got, r_exp);
      k++;
      if (r_ret) begin
        seen = 1'b1;
        total += 2;
        if (!r_hit || r_got !== r_exp) begin
          bad++;
          $display("FAIL mid_sb got=%h want=%h", r_got, r_exp);
        end
        if (r_got !== 17'h01236) begin
          bad++;
          $display("FAIL mid_first got=%h want=01236", r_got);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_timeout got=none want=result");
    end
  endtask

  task automatic test_single_stage();
    logic [8:0] ex;
    a1 = 8'hFF;
    b1 = 8'h01;
    c1 = 1'b0;
    v1 = 1'b1;
    ex = 9'h100;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      total += 3;
      if (ov1 !== 1'b1) begin
        bad++;
        $display("FAIL s1_valid got=%b want=1", ov1);
      end
      if ({co1, s1} !== ex) begin
        bad++;
        $display("FAIL s1_sum got=%h want=%h", {co1, s1}, ex);
      end
      if (ir1 !== 1'b1) begin
        bad++;
        $display("FAIL s1_ready got=%b want=1", ir1);
      end
      a1 = 8'($urandom);
      b1 = 8'($urandom);
      c1 = 1'($urandom);
      ex = {1'b0, a1} + {1'b0, b1} + {8'h00, c1};
    end
    v1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ov1 !== 1'b0) begin
      bad++;
      $display("FAIL s1_bubble got=%b want=0", ov1);
    end
  endtask

`ifdef MA_PIPE_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] ta[2];
    logic [W:0]   ts[2];
    logic         to[2];
    ta[0] = 16'h7FFF;
    ts[0] = 17'h08000;
    to[0] = 1'b1;
    ta[1] = 16'hFFFF;
    ts[1] = 17'h10000;
    to[1] = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1;
      A   = ta[t];
      B   = 16'h0001;
      Cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 1; i < ST; i++) @(negedge clk);
      total += 3;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL ovf_valid got=%b want=1", out_valid);
      end
      if ({Cout, S} !== ts[t]) begin
        bad++;
        $display("FAIL ovf_sum got=%h want=%h", {Cout, S}, ts[t]);
      end
      if (ovf !== to[t]) begin
        bad++;
        $display("FAIL ovf_flag got=%b want=%b", ovf, to[t]);
      end
      @(negedge clk);
    end
    a1 = 8'h7F;
    b1 = 8'h01;
    c1 = 1'b0;
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    total++;
    if (ovf1 !== 1'b1) begin
      bad++;
      $display("FAIL ovf1_flag got=%b want=1", ovf1);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    out_ready = 1'b1;
    v1        = 1'b0;
    a1        = '0;
    b1        = '0;
    c1        = 1'b0;
    r1        = 1'b1;
    test_reset();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_mid();
    test_single_stage();
`ifdef MA_PIPE_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ma_pipe_adder.md
# ma_pipe_adder

Parametrised, pipelined successor to the team's 4-bit ripple multi-bit adder. Adds two WIDTH-bit operands plus carry-in, splitting the carry chain into SEG-bit ripple segments with a register stage after each segment. Accepts one operation per cycle through a valid/ready handshake with back-pressure. Sits in datapaths where a full-width ripple chain misses timing.

## Interface
- WIDTH, 16, operand/sum width; must be an integer multiple of SEG.
- SEG, 4, bits of ripple carry per pipeline stage, SEG >= 1.
- STAGES (derived, not overridable) = WIDTH/SEG.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  A, B, Cin valid this cycle.
- in_ready  out  1  block accepts the operation this cycle.
- A  in  WIDTH  operand A (unsigned; two's complement under MA_PIPE_OVF_EN).
- B  in  WIDTH  operand B.
- Cin  in  1  carry into bit 0.
- out_valid  out  1  S/Cout hold a result.
- out_ready  in  1  downstream consumes the result this cycle.
- S  out  WIDTH  sum, A+B+Cin mod 2^WIDTH.
- Cout  out  1  carry out of bit WIDTH-1.
- Ovf  out  1  signed overflow; present only with MA_PIPE_OVF_EN.

## Operation
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] of the sum from that segment of A, B and the carry registered by stage k-1 (stage 0 uses Cin).
- Upper operand segments are skewed through delay registers so each reaches stage k in step with its carry; lower sum segments are delayed so all of S emerges in the same cycle.
- Each stage carries a valid bit. Global advance: adv = !out_valid || out_ready. When adv=1 every stage shifts one step; when adv=0 all stage registers, including valid bits, hold.
- in_ready = adv (combinational from out_valid/out_ready). Handshake occurs when in_valid && in_ready; in_valid=1 with in_ready=0 loads nothing.
- in_valid=0 while adv=1 inserts a bubble; bubbles are not collapsed.
- Output register is the last stage: S, Cout (and Ovf) change only when adv=1; they are stable while out_valid=1 && out_ready=0.
- Arithmetic: {Cout, S} = A + B + Cin, WIDTH+1 bits, no saturation.

## Timing
- Reset (rst_n=0, asynchronous): all valid bits 0, out_valid=0, S=0, Cout=0, Ovf=0, all internal data/carry registers 0. in_ready=1 during and after reset.
- Reset mid-operation: all in-flight operations discarded; first result after release only comes from an operation accepted after release.
- Latency: STAGES cycles from acceptance edge to out_valid=1 (WIDTH=16, SEG=4: accepted at edge n, visible after edge n+3, i.e. STAGES-1 cycles after the accept cycle's edge plus the final output register; exactly STAGES rising edges including the accepting edge).
- STAGES=1: pure single-register adder, latency 1.
- Throughput: one operation per cycle when out_ready=1.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: result retires and new operand enters on the same edge.
- Order preserved; no operation lost or duplicated under any stall pattern.

## Configuration
- MA_PIPE_OVF_EN defined: port Ovf exists; Ovf = carry into bit WIDTH-1 XOR Cout, registered and aligned with S; reset 0, held on stall.
- Not defined: Ovf port and its logic absent; interface and timing otherwise identical.

## Test plan
- Reset: rst_n=0 asynchronously mid-clock -> out_valid=0, S=0, Cout=0 immediately; in_ready=1.
- WIDTH=16, SEG=4, out_ready=1: A=0xFFFF, B=0x0001, Cin=0 -> after 4 edges out_valid=1, S=0x0000, Cout=1 (full carry ripple across all stages).
- Back-to-back stream of 100 random {A,B,Cin}, out_ready=1 -> results in order, one per cycle, each equal to A+B+Cin.
- Back-pressure: out_ready held 0 for 5 cycles with pipe full -> in_ready=0, S/Cout/out_valid unchanged; on release, no loss or duplication; random out_ready toggling over 1000 ops matches scoreboard.
- Reset mid-stream with 3 ops in flight -> none emerge after release; next accepted op A=0x1234,B=0x0001,Cin=1 gives S=0x1236, Cout=0.
- With MA_PIPE_OVF_EN: A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Ovf=1, Cout=0; A=0xFFFF, B=0x0001 -> Ovf=0, Cout=1. Also run WIDTH=8, SEG=8 (STAGES=1, latency 1).
